// File: rtl/croc_switch_debounce.sv
// croc_switch_debounce
// Debounces the board switch inputs (gpio_i[3:0] plus fetch_en_i) for the SoC.
// Each channel is synchronized, then its output follows the synchronized level
// only after that level has disagreed with the output for DebounceCycles
// consecutive soc_clk cycles. Channels are fully independent.
//
// Ports:
//   soc_clk : SoC clock, all state on its rising edge
//   rst_n   : asynchronous active-low reset
//   sw_i    : raw, asynchronous, bouncing switch levels
//   sw_o    : debounced, soc_clk-synchronous switch levels
//   rise_o  : one-cycle pulse when a sw_o bit goes 0->1
//   fall_o  : one-cycle pulse when a sw_o bit goes 1->0
module croc_switch_debounce #(
    parameter int unsigned      NumSw          = 5,
    parameter int unsigned      SyncStages     = 2,
    parameter int unsigned      DebounceCycles = 20000,
    parameter logic [NumSw-1:0] ResetValue     = '0
) (
    input  logic             soc_clk,
    input  logic             rst_n,
    input  logic [NumSw-1:0] sw_i,
    output logic [NumSw-1:0] sw_o,
    output logic [NumSw-1:0] rise_o,
    output logic [NumSw-1:0] fall_o
);

    // Guard the width so an illegal DebounceCycles = 0 still elaborates far
    // enough to reach the error below instead of a zero-width vector.
    localparam int unsigned CntW = (DebounceCycles == 0) ? 1 : $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    if (DebounceCycles == 0) begin : gen_bad_debounce
        $error("croc_switch_debounce: DebounceCycles must be >= 1");
    end
    if (SyncStages < 2 || SyncStages > 4) begin : gen_bad_sync
        $error("croc_switch_debounce: SyncStages must be in 2..4");
    end

    logic [NumSw-1:0] sync_q [SyncStages];
    logic [NumSw-1:0] sync_s;
    logic [NumSw-1:0] sw_d, sw_q;
    logic [NumSw-1:0] rise_d, rise_q;
    logic [NumSw-1:0] fall_d, fall_q;
    logic [CntW-1:0]  cnt_d [NumSw];
    logic [CntW-1:0]  cnt_q [NumSw];

    // Synchronizer chain; resets to ResetValue so a switch already at its
    // reset level produces no spurious edge after reset.
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SyncStages; i++) begin
                sync_q[i] <= ResetValue;
            end
        end else begin
            sync_q[0] <= sw_i;
            for (int i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SyncStages-1];

    // Per channel: counter is zero while the synchronized level matches the
    // output, and counts cycles of disagreement otherwise. When the count
    // completes the output takes the new level and one edge pulse is raised.
    always_comb begin
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        for (int c = 0; c < NumSw; c++) begin
            cnt_d[c] = '0;
            if (sync_s[c] != sw_q[c]) begin
                if (cnt_q[c] == CntLast) begin
                    sw_d[c]   = sync_s[c];
                    rise_d[c] = sync_s[c];
                    fall_d[c] = ~sync_s[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q   <= ResetValue;
            rise_q <= '0;
            fall_q <= '0;
            for (int c = 0; c < NumSw; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            sw_q   <= sw_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int c = 0; c < NumSw; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign sw_o   = sw_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule
